conv_4x4_acc: RTL and testbench
===============================

# conv_4x4_acc

Result collector on the output side of the 4x4 systolic convolution array. It accepts the array's 4-beat 64-bit result bursts and accumulates partial 4x4 tiles over a configurable number of input-channel passes. It requantizes each finished tile (arithmetic shift plus 16-bit saturation) and drains it row by row over a valid/ready stream toward the output feature-map writer. Two accumulation banks (ping-pong) let a new tile arrive while the previous one drains; the producer cannot be stalled.

## Interface
- WIDTH, 16, element width of input and output lanes
- ACC_W, 24, accumulator width per element
- PASS_W, 8, width of pass-count input
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_num_pass  in  PASS_W  passes per output tile; 0 is treated as 1; sampled on the first beat of each tile
- i_shift  in  4  right arithmetic shift applied at drain; static while any bank is full
- i_data_en  in  1  input beat valid; cannot be back-pressured
- i_data  in  64  one row: {c0,c1,c2,c3}, c0 at [63:48], signed WIDTH each
- o_data  out  64  requantized row, same lane order
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts o_data
- o_err  out  1  sticky overflow flag: a beat hit a bank still holding an undrained tile

## Operation
- Input counters: beat (0..3 = row index) and pass (0..num_pass-1). Each i_data_en beat advances beat; beat 3 wraps to 0 and advances pass. The last beat of the last pass wraps pass to 0, marks the current accumulate bank full, and switches the accumulate target to the other bank. Gaps between beats are allowed; counting is by beats, not cycles.
- Accumulate write for element (row=beat, col c):
  - pass 0: acc = sign-extend(lane).
  - passes > 0: acc = sat_ACC_W(acc + sign-extend(lane)).
- Overflow: a beat whose target bank is full is discarded, and o_err is set to 1 until reset. Counters still advance, so tile alignment is preserved.
- Drain: the oldest full bank is drained first. Row counter r = 0..3; o_valid = 1 while a bank is full.
  - Lane c = sat_WIDTH(acc[r][c] >>> i_shift), combinational from the bank and r.
  - Each o_valid&&i_ready advances r. Acceptance of row 3 clears the bank's full flag and resets r to 0.
- Simultaneous events:
  - If the first beat into a bank and the acceptance of that bank's row 3 happen on the same edge, the beat is accepted and o_err is not set.
  - If a tile completes on the same edge that the other bank finishes draining, o_valid stays 1 for the new tile with no bubble.
- When o_valid = 0, o_data = 0.

## Timing
- Reset (asynchronous assert, synchronous release): o_valid=0, o_data=0, o_err=0. Banks cleared, full flags cleared, counters 0, accumulate target = bank 0, drain pointer = bank 0.
- Reset asserted mid-tile or mid-drain discards all state immediately.
- Latency: the last beat of a tile sampled at edge T gives o_valid=1 and row 0 on o_data in the cycle after T.
- With i_ready held high, rows 0..3 drain in 4 consecutive cycles.
- o_data and o_valid remain stable while o_valid && !i_ready.
- The array emits bursts at most every 16 cycles, so a steady-state drain with i_ready=1 never overflows.

## Test plan
- num_pass=1, shift=0, row r lanes {4r+1..4r+4}, i_ready=1: 4 rows out equal to the inputs, o_valid high exactly 4 cycles starting the cycle after beat 3; o_err=0.
- num_pass=3, every lane 0x0100 for all 12 beats: single tile out with all lanes 0x0300; no o_valid during passes 0-1.
- num_pass=2:
  - all lanes 0x7FFF, shift=0: output 0x7FFF.
  - same tile, shift=1: output 0x7FFF (0xFFFE>>>1).
  - all lanes 0x8000, shift=0: output 0x8000.
  - all lanes 0x8000, shift=4: output 0xF000.
- i_ready=0, three num_pass=1 tiles A, B, C: tile C dropped and o_err=1. Then i_ready=1 drains A then B (8 rows), o_valid falls, and o_err stays 1.
- Backpressure: toggle i_ready randomly during a drain while the next tile arrives in the other bank. All 8 rows arrive in order, o_data is held stable while stalled, and the same-edge free/first-beat case gives o_err=0.
- Assert rst low during drain row 2: o_valid and o_data go to 0 without waiting for a clock edge. After release, a fresh num_pass=1 tile drains correctly from bank 0.

Source files
------------

// File: rtl/conv_4x4_acc.sv
// Output-side collector for the 4x4 systolic array: accumulates 4-beat row bursts
// over several channel passes into ping-pong banks, then drains requantized rows.
module conv_4x4_acc #(
    parameter int WIDTH  = 16,
    parameter int ACC_W  = 24,
    parameter int PASS_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PASS_W-1:0]    i_num_pass,
    input  logic [3:0]           i_shift,
    input  logic                 i_data_en,
    input  logic [4*WIDTH-1:0]   i_data,
    output logic [4*WIDTH-1:0]   o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_err
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [WIDTH-1:0]        OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]        OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [ACC_W-1:0] acc [2][4][4];
    logic [1:0]              full;
    logic                    wr_bank, rd_bank, rd_sel;
    logic [1:0]              beat, row;
    logic [PASS_W-1:0]       pass, num_pass_q, npass_eff;
    logic                    tile_first, last_beat, drain_done, blocked;
    logic [1:0]              full_set, full_clr;
    logic signed [ACC_W-1:0] lane_ext [4];
    logic signed [ACC_W-1:0] acc_next [4];

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
        if (v[ACC_W] != v[ACC_W-1]) return v[ACC_W] ? ACC_MIN : ACC_MAX;
        return v[ACC_W-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        if ((&v[ACC_W-1:WIDTH-1]) || !(|v[ACC_W-1:WIDTH-1])) return v[WIDTH-1:0];
        return v[ACC_W-1] ? OUT_MIN : OUT_MAX;
    endfunction

    // Follow the registered pointer while its bank is full, otherwise the other bank;
    // this keeps draining correct after a dropped tile breaks strict alternation.
    assign rd_sel     = full[rd_bank] ? rd_bank : ~rd_bank;
    assign o_valid    = |full;
    assign tile_first = (beat == 2'd0) && (pass == '0);
    assign npass_eff  = !tile_first ? num_pass_q :
                        ((i_num_pass == '0) ? PASS_W'(1) : i_num_pass);
    assign last_beat  = (beat == 2'd3) && (pass == npass_eff - PASS_W'(1));
    assign drain_done = o_valid && i_ready && (row == 2'd3);
    assign blocked    = full[wr_bank] && !(drain_done && (rd_sel == wr_bank));

    assign full_set = (i_data_en && last_beat) ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign full_clr = drain_done ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            lane_ext[c] = ACC_W'($signed(i_data[(3-c)*WIDTH +: WIDTH]));
            acc_next[c] = lane_ext[c];
            if (pass != '0)
                acc_next[c] = sat_acc({acc[wr_bank][beat][c][ACC_W-1], acc[wr_bank][beat][c]} +
                                      {lane_ext[c][ACC_W-1], lane_ext[c]});
        end
    end

    always_comb begin
        o_data = '0;
        if (o_valid)
            for (int c = 0; c < 4; c++)
                o_data[(3-c)*WIDTH +: WIDTH] = sat_out(acc[rd_sel][row][c] >>> i_shift);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        acc[b][r][c] <= '0;
            full       <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            beat       <= '0;
            row        <= '0;
            pass       <= '0;
            num_pass_q <= PASS_W'(1);
            o_err      <= 1'b0;
        end else begin
            if (i_data_en) begin
                if (tile_first) num_pass_q <= npass_eff;
                beat <= beat + 2'd1;
                if (beat == 2'd3) pass <= last_beat ? '0 : pass + PASS_W'(1);
                if (last_beat) wr_bank <= ~wr_bank;
                if (blocked)
                    o_err <= 1'b1;
                else
                    for (int c = 0; c < 4; c++)
                        acc[wr_bank][beat][c] <= acc_next[c];
            end
            if (o_valid && i_ready) row <= row + 2'd1;
            rd_bank <= drain_done ? ~rd_sel : rd_sel;
            full    <= full_set | (full & ~full_clr);
        end
    end

endmodule

// File: tb/tb_conv_4x4_acc.sv
// Scoreboard bench for conv_4x4_acc: a reference accumulator pushes expected rows
// when a tile is driven; a negedge monitor pops and compares as rows are accepted.
module tb_conv_4x4_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_num_pass;
    logic [3:0]  i_shift;
    logic        i_data_en;
    logic [63:0] i_data;
    logic [63:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_err;

    logic [63:0] exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          exp_err = 1'b0;

    conv_4x4_acc #(.WIDTH(16), .ACC_W(24), .PASS_W(8)) dut (
        .clk(clk), .rst(rst), .i_num_pass(i_num_pass), .i_shift(i_shift),
        .i_data_en(i_data_en), .i_data(i_data), .o_data(o_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int sat24(input int v);
        if (v > 8388607)  return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    function automatic logic [15:0] sat16(input int v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (o_valid) begin
                if (exp_q.size() == 0)      chk("unexpected_valid", 64'(o_valid), 64'd0);
                else if (i_ready)           chk("row", o_data, exp_q.pop_front());
                else                        chk("stall_hold", o_data, exp_q[0]);
            end else begin
                chk("idle_zero", o_data, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: lane = base+4r+c, mode 1: every lane = base, mode 2: random lanes
    task automatic send_tile(input int np, input int mode, input int base,
                             input bit drop, input bit gaps);
        int          macc[4][4];
        int          np_e;
        logic [15:0] v16;
        logic [63:0] beat_w;
        logic [63:0] row_w;
        np_e = (np == 0) ? 1 : np;
        i_num_pass = 8'(np);
        for (int p = 0; p < np_e; p++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    case (mode)
                        0:       v16 = 16'(base + 4*r + c);
                        1:       v16 = 16'(base);
                        default: v16 = 16'($urandom_range(0, 65535));
                    endcase
                    beat_w[63-16*c -: 16] = v16;
                    if (p == 0) macc[r][c] = int'($signed(v16));
                    else        macc[r][c] = sat24(macc[r][c] + int'($signed(v16)));
                end
                if (p == np_e-1 && r == 3) begin
                    if (drop) exp_err = 1'b1;
                    else
                        for (int rr = 0; rr < 4; rr++) begin
                            for (int c = 0; c < 4; c++)
                                row_w[63-16*c -: 16] = sat16(macc[rr][c] >>> i_shift);
                            exp_q.push_back(row_w);
                        end
                end
                i_data    = beat_w;
                i_data_en = 1'b1;
                tick();
                i_data_en = 1'b0;
                if (gaps) repeat ($urandom_range(0, 2)) tick();
            end
        end
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_rows_left"}, 64'(exp_q.size()), 64'd0);
        tick();
        chk({tag, "_valid_low"}, 64'(o_valid), 64'd0);
        chk({tag, "_err"}, 64'(o_err), 64'(exp_err));
    endtask

    initial begin
        rst = 1'b0; i_num_pass = 8'd1; i_shift = 4'd0;
        i_data_en = 1'b0; i_data = '0; i_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        rst = 1'b1;
        tick();

        // single pass, pass-through, exact 4-cycle drain
        send_tile(1, 0, 1, 0, 0);
        chk("latency_valid", 64'(o_valid), 64'd1);
        repeat (3) tick();
        chk("valid_4th", 64'(o_valid), 64'd1);
        tick();
        chk("valid_after4", 64'(o_valid), 64'd0);
        wait_empty("t1");

        // pass count 0 behaves as 1
        send_tile(0, 2, 0, 0, 0);
        wait_empty("np0");

        // three passes with gaps
        send_tile(3, 1, 16'h0100, 0, 1);
        wait_empty("t2");

        // saturation and shift corners
        i_shift = 4'd0; send_tile(2, 1, 16'h7FFF, 0, 0); wait_empty("pos_s0");
        i_shift = 4'd1; send_tile(2, 1, 16'h7FFF, 0, 0); wait_empty("pos_s1");
        i_shift = 4'd0; send_tile(2, 1, 16'h8000, 0, 0); wait_empty("neg_s0");
        i_shift = 4'd4; send_tile(2, 1, 16'h8000, 0, 0); wait_empty("neg_s4");
        i_shift = 4'd3; send_tile(3, 2, 0, 0, 1);        wait_empty("rand_s3");
        i_shift = 4'd0;

        // random backpressure while the next tile fills the other bank
        fork
            begin
                send_tile(1, 2, 0, 0, 0);
                repeat (2) tick();
                send_tile(2, 2, 0, 0, 1);
            end
            begin
                repeat (30) begin
                    i_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        i_ready = 1'b1;
        wait_empty("bp");

        // first beat into a bank on the same edge its row 3 is accepted
        i_ready = 1'b0;
        send_tile(1, 0, 16'h0040, 0, 0);
        send_tile(1, 0, 16'h0050, 0, 0);
        chk("both_full_valid", 64'(o_valid), 64'd1);
        i_ready = 1'b1;
        repeat (3) tick();
        send_tile(1, 0, 16'h0060, 0, 0);
        wait_empty("same_edge");

        // overflow: third tile dropped, error sticky
        i_ready = 1'b0;
        send_tile(1, 0, 16'h0010, 0, 0);
        send_tile(1, 0, 16'h0020, 0, 0);
        send_tile(1, 0, 16'h0030, 1, 0);
        chk("ovf_err", 64'(o_err), 64'd1);
        i_ready = 1'b1;
        wait_empty("ovf");

        // async reset in the middle of draining row 2
        rst = 1'b0; tick(); rst = 1'b1; exp_err = 1'b0; tick();
        chk("rst2_err", 64'(o_err), 64'd0);
        i_ready = 1'b0;
        send_tile(1, 2, 0, 0, 0);
        i_ready = 1'b1;
        tick(); tick();
        i_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 64'(o_valid), 64'd0);
        chk("async_data", o_data, 64'd0);
        exp_q.delete();
        tick(); tick();
        rst = 1'b1;
        i_ready = 1'b1;
        tick();
        send_tile(1, 0, 16'h0700, 0, 0);
        chk("post_rst_valid", 64'(o_valid), 64'd1);
        wait_empty("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
